// File: rtl/regs_wb.sv
// Writeback pipeline register + integer register file with two bypassed read ports.
// Define REGS_WB_ARRAY_RESET_EN to clear the whole array on rst; otherwise the array has no reset.
module regs_wb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int REG_NUM = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ex_waddr_i,
  input  logic              ex_we_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_waddr_o
);

  localparam logic [ADDR_W:0] LP_REG_NUM = (ADDR_W+1)'(REG_NUM);

  logic [DATA_W-1:0] r_regs [REG_NUM];
  logic              r_wb_we;
  logic [ADDR_W-1:0] r_wb_waddr;
  logic [DATA_W-1:0] r_wb_wdata;
  logic              w_commit;

  function automatic logic f_in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < LP_REG_NUM);
  endfunction

  // Read mux: x0 / disabled / out-of-range first, then newest producer wins.
  function automatic logic [DATA_W-1:0] f_read(input logic re, input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] v;
    if (rst || !re || (addr == {ADDR_W{1'b0}}) || !f_in_range(addr)) begin
      v = {DATA_W{1'b0}};
    end else if (ex_we_i && (ex_waddr_i == addr)) begin
      v = ex_wdata_i;
    end else if (r_wb_we && (r_wb_waddr == addr)) begin
      v = r_wb_wdata;
    end else begin
      v = r_regs[addr];
    end
    return v;
  endfunction

  assign w_commit = r_wb_we && (r_wb_waddr != {ADDR_W{1'b0}}) && f_in_range(r_wb_waddr);

  // Writeback register: flush inserts a bubble and overrides stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_we    <= 1'b0;
      r_wb_waddr <= {ADDR_W{1'b0}};
      r_wb_wdata <= {DATA_W{1'b0}};
    end else if (flush_i) begin
      r_wb_we <= 1'b0;
    end else if (!stall_i) begin
      r_wb_we    <= ex_we_i;
      r_wb_waddr <= ex_waddr_i;
      r_wb_wdata <= ex_wdata_i;
    end
  end

`ifdef REGS_WB_ARRAY_RESET_EN
  // Register array commit, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end
    end else if (w_commit) begin
      r_regs[r_wb_waddr] <= r_wb_wdata;
    end
  end
`else
  // Register array commit; no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (!rst && w_commit) begin
      r_regs[r_wb_waddr] <= r_wb_wdata;
    end
  end
`endif

  // Combinational read ports.
  always_comb begin
    rdata1_o = f_read(re1_i, raddr1_i);
    rdata2_o = f_read(re2_i, raddr2_i);
  end

  assign wb_we_o    = r_wb_we;
  assign wb_waddr_o = r_wb_waddr;

endmodule

// File: tb/tb_regs_wb.sv
// Self-checking bench for regs_wb: directed scenarios plus randomized traffic vs a reference model.
module tb_regs_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ex_waddr_i;
  logic        ex_we_i;
  logic [31:0] ex_wdata_i;
  logic        stall_i, flush_i;
  logic        re1_i, re2_i;
  logic [4:0]  raddr1_i, raddr2_i;
  logic [31:0] rdata1_o, rdata2_o;
  logic        wb_we_o;
  logic [4:0]  wb_waddr_o;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural state plus one pending result.
  logic [31:0] m_regs  [32];
  bit          m_valid [32];
  bit          m_wb_we;
  logic [4:0]  m_wb_addr;
  logic [31:0] m_wb_data;

  regs_wb dut (
    .clk(clk), .rst(rst),
    .ex_waddr_i(ex_waddr_i), .ex_we_i(ex_we_i), .ex_wdata_i(ex_wdata_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .re1_i(re1_i), .raddr1_i(raddr1_i), .rdata1_o(rdata1_o),
    .re2_i(re2_i), .raddr2_i(raddr2_i), .rdata2_o(rdata2_o),
    .wb_we_o(wb_we_o), .wb_waddr_o(wb_waddr_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle();
    ex_we_i = 1'b0; ex_waddr_i = 5'd0; ex_wdata_i = 32'd0;
    stall_i = 1'b0; flush_i = 1'b0;
    re1_i = 1'b0; re2_i = 1'b0; raddr1_i = 5'd0; raddr2_i = 5'd0;
  endtask

  task automatic model_reset();
    m_wb_we = 1'b0; m_wb_addr = 5'd0; m_wb_data = 32'd0;
    for (int i = 0; i < 32; i++) begin
`ifdef REGS_WB_ARRAY_RESET_EN
      m_regs[i] = 32'd0; m_valid[i] = 1'b1;
`else
      m_valid[i] = 1'b0;
`endif
    end
  endtask

  // Advance one clock; inputs are stable across the edge, model updated from them.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      if (m_wb_we && m_wb_addr != 5'd0) begin
        m_regs[m_wb_addr] = m_wb_data;
        m_valid[m_wb_addr] = 1'b1;
      end
      if (flush_i) m_wb_we = 1'b0;
      else if (!stall_i) begin
        m_wb_we = ex_we_i; m_wb_addr = ex_waddr_i; m_wb_data = ex_wdata_i;
      end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic ex_write(input logic [4:0] a, input logic [31:0] d);
    idle();
    ex_we_i = 1'b1; ex_waddr_i = a; ex_wdata_i = d;
    tick();
    idle();
  endtask

  // Expected read value; returns 0 when the value is undefined (unwritten, no array reset).
  function automatic bit exp_read(input logic re, input logic [4:0] a, output logic [31:0] v);
    v = 32'd0;
    exp_read = 1'b1;
    if (rst || !re || a == 5'd0) v = 32'd0;
    else if (ex_we_i && ex_waddr_i == a) v = ex_wdata_i;
    else if (m_wb_we && m_wb_addr == a) v = m_wb_data;
    else if (m_valid[a]) v = m_regs[a];
    else exp_read = 1'b0;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    idle();
    re1_i = 1'b1; re2_i = 1'b1; raddr1_i = 5'd5; raddr2_i = 5'd5;
    ex_we_i = 1'b1; ex_waddr_i = 5'd5; ex_wdata_i = 32'hDEAD_BEEF;
    #2;
    checks++; if (rdata1_o !== 32'd0) begin errors++; $display("FAIL reset_rdata1 got %h exp %h", rdata1_o, 32'd0); end
    checks++; if (rdata2_o !== 32'd0) begin errors++; $display("FAIL reset_rdata2 got %h exp %h", rdata2_o, 32'd0); end
    checks++; if (wb_we_o !== 1'b0) begin errors++; $display("FAIL reset_wb_we got %b exp 0", wb_we_o); end
    checks++; if (wb_waddr_o !== 5'd0) begin errors++; $display("FAIL reset_wb_waddr got %h exp 0", wb_waddr_o); end
    tick(); tick();
    rst = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_commit();
    ex_write(5'd1, 32'h0000_1234);
    tick(); tick();
    re1_i = 1'b1; raddr1_i = 5'd1;
    #1;
    checks++; if (rdata1_o !== 32'h0000_1234) begin errors++; $display("FAIL commit_x1 got %h exp %h", rdata1_o, 32'h0000_1234); end
    checks++; if (wb_we_o !== 1'b0) begin errors++; $display("FAIL commit_wb_idle got %b exp 0", wb_we_o); end
  endtask

  task automatic test_bypass();
    idle();
    ex_we_i = 1'b1; ex_waddr_i = 5'd2; ex_wdata_i = 32'hA5A5_0000;
    re1_i = 1'b1; raddr1_i = 5'd2;
    #1;
    checks++; if (rdata1_o !== 32'hA5A5_0000) begin errors++; $display("FAIL bypass_ex got %h exp %h", rdata1_o, 32'hA5A5_0000); end
    tick();
    ex_we_i = 1'b0;
    #1;
    checks++; if (rdata1_o !== 32'hA5A5_0000) begin errors++; $display("FAIL bypass_wb got %h exp %h", rdata1_o, 32'hA5A5_0000); end
    checks++; if (wb_we_o !== 1'b1 || wb_waddr_o !== 5'd2) begin errors++; $display("FAIL bypass_wb_pending got we=%b addr=%h exp we=1 addr=02", wb_we_o, wb_waddr_o); end
    ex_we_i = 1'b1; ex_wdata_i = 32'h0000_0001;
    #1;
    checks++; if (rdata1_o !== 32'h0000_0001) begin errors++; $display("FAIL bypass_ex_wins got %h exp %h", rdata1_o, 32'h0000_0001); end
    tick();
    idle();
    tick(); tick();
  endtask

  task automatic test_x0();
    idle();
    ex_we_i = 1'b1; ex_waddr_i = 5'd0; ex_wdata_i = 32'hFFFF_FFFF;
    re1_i = 1'b1; re2_i = 1'b1;
    #1;
    checks++; if (rdata1_o !== 32'd0 || rdata2_o !== 32'd0) begin errors++; $display("FAIL x0_same_cycle got %h/%h exp 0/0", rdata1_o, rdata2_o); end
    tick();
    ex_we_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (rdata1_o !== 32'd0 || rdata2_o !== 32'd0) begin errors++; $display("FAIL x0_cycle%0d got %h/%h exp 0/0", i, rdata1_o, rdata2_o); end
      tick();
    end
    idle();
  endtask

  task automatic test_stall_flush();
    ex_write(5'd3, 32'h0000_0033);
    ex_write(5'd8, 32'h0000_0088);
    stall_i = 1'b1; ex_we_i = 1'b1; ex_waddr_i = 5'd3; ex_wdata_i = 32'h0000_0007;
    tick();
    checks++; if (wb_waddr_o !== 5'd8 || wb_we_o !== 1'b1) begin errors++; $display("FAIL stall_hold got we=%b addr=%h exp we=1 addr=08", wb_we_o, wb_waddr_o); end
    ex_we_i = 1'b0; re1_i = 1'b1; raddr1_i = 5'd3;
    #1;
    checks++; if (rdata1_o !== 32'h0000_0033) begin errors++; $display("FAIL stall_no_write got %h exp %h", rdata1_o, 32'h0000_0033); end
    flush_i = 1'b1; ex_we_i = 1'b1;
    tick();
    checks++; if (wb_we_o !== 1'b0) begin errors++; $display("FAIL flush_beats_stall got %b exp 0", wb_we_o); end
    idle();
    tick();
    re1_i = 1'b1; raddr1_i = 5'd3; re2_i = 1'b1; raddr2_i = 5'd8;
    #1;
    checks++; if (rdata1_o !== 32'h0000_0033) begin errors++; $display("FAIL flush_no_commit got %h exp %h", rdata1_o, 32'h0000_0033); end
    checks++; if (rdata2_o !== 32'h0000_0088) begin errors++; $display("FAIL stall_commit_x8 got %h exp %h", rdata2_o, 32'h0000_0088); end
    idle();
  endtask

  task automatic test_dual_port();
    ex_write(5'd4, 32'h0000_0011);
    ex_write(5'd6, 32'h0000_0022);
    tick(); tick();
    re1_i = 1'b1; raddr1_i = 5'd4; re2_i = 1'b1; raddr2_i = 5'd6;
    #1;
    checks++; if (rdata1_o !== 32'h0000_0011) begin errors++; $display("FAIL dual_p1 got %h exp %h", rdata1_o, 32'h0000_0011); end
    checks++; if (rdata2_o !== 32'h0000_0022) begin errors++; $display("FAIL dual_p2 got %h exp %h", rdata2_o, 32'h0000_0022); end
    re2_i = 1'b0;
    #1;
    checks++; if (rdata2_o !== 32'd0) begin errors++; $display("FAIL dual_re2_off got %h exp 0", rdata2_o); end
    re2_i = 1'b1; raddr2_i = 5'd4;
    #1;
    checks++; if (rdata1_o !== 32'h0000_0011 || rdata2_o !== 32'h0000_0011) begin errors++; $display("FAIL dual_same_addr got %h/%h exp 11/11", rdata1_o, rdata2_o); end
    idle();
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    bit k1, k2;
    for (int n = 0; n < 400; n++) begin
      ex_we_i    = ($urandom_range(0, 3) != 0);
      ex_waddr_i = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      ex_wdata_i = $urandom;
      stall_i    = ($urandom_range(0, 5) == 0);
      flush_i    = ($urandom_range(0, 7) == 0);
      re1_i      = ($urandom_range(0, 7) != 0);
      re2_i      = ($urandom_range(0, 7) != 0);
      raddr1_i   = 5'($urandom_range(0, 7));
      raddr2_i   = ($urandom_range(0, 1) == 0) ? raddr1_i : 5'($urandom_range(0, 31));
      #1;
      k1 = exp_read(re1_i, raddr1_i, e1);
      k2 = exp_read(re2_i, raddr2_i, e2);
      if (k1) begin
        checks++; if (rdata1_o !== e1) begin errors++; $display("FAIL rand_p1 n=%0d addr=%0d got %h exp %h", n, raddr1_i, rdata1_o, e1); end
      end
      if (k2) begin
        checks++; if (rdata2_o !== e2) begin errors++; $display("FAIL rand_p2 n=%0d addr=%0d got %h exp %h", n, raddr2_i, rdata2_o, e2); end
      end
      checks++; if (wb_we_o !== m_wb_we || wb_waddr_o !== m_wb_addr) begin errors++; $display("FAIL rand_wb n=%0d got we=%b addr=%h exp we=%b addr=%h", n, wb_we_o, wb_waddr_o, m_wb_we, m_wb_addr); end
      tick();
    end
    idle();
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    ex_write(5'd5, 32'h0000_0055);
    ex_write(5'd7, 32'h0000_0077);
    re1_i = 1'b1; raddr1_i = 5'd7; re2_i = 1'b1; raddr2_i = 5'd5;
    rst = 1'b1;
    model_reset();
    #1;
    checks++; if (rdata1_o !== 32'd0 || rdata2_o !== 32'd0) begin errors++; $display("FAIL midrst_rdata got %h/%h exp 0/0", rdata1_o, rdata2_o); end
    checks++; if (wb_we_o !== 1'b0 || wb_waddr_o !== 5'd0) begin errors++; $display("FAIL midrst_wb got we=%b addr=%h exp we=0 addr=00", wb_we_o, wb_waddr_o); end
    tick();
    rst = 1'b0;
    idle();
    tick();
    checks++; if (wb_we_o !== 1'b0) begin errors++; $display("FAIL midrst_after_wb got %b exp 0", wb_we_o); end
`ifdef REGS_WB_ARRAY_RESET_EN
    re1_i = 1'b1; raddr1_i = 5'd5; re2_i = 1'b1; raddr2_i = 5'd7;
    #1;
    checks++; if (rdata1_o !== 32'd0) begin errors++; $display("FAIL midrst_x5 got %h exp 0", rdata1_o); end
    checks++; if (rdata2_o !== 32'd0) begin errors++; $display("FAIL midrst_x7_dropped got %h exp 0", rdata2_o); end
`endif
    idle();
  endtask

  initial begin
    test_reset();
    test_commit();
    test_bypass();
    test_x0();
    test_stall_flush();
    test_dual_port();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
